// File: rtl/fft32_frame_sequencer.sv
// Run-time controller for the fft32 streaming kernel: sequences ap_start/ap_ready/ap_done
// per frame, checks stream TLAST placement, and latches a stall watchdog fault.
module fft32_frame_sequencer #(
  parameter int FRAME_LEN  = 32,
  parameter int CNT_W      = 6,
  parameter int WDOG_W     = 16,
  parameter int WDOG_LIMIT = 1000
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic        cfg_enable,
  input  logic [15:0] cfg_num_frames,
  input  logic        cmd_start,
  input  logic        cmd_abort,
  output logic        kernel_ap_start,
  input  logic        kernel_ap_ready,
  input  logic        kernel_ap_done,
  input  logic        in_tvalid,
  input  logic        in_tready,
  input  logic        in_tlast,
  input  logic        out_tvalid,
  input  logic        out_tready,
  input  logic        out_tlast,
  output logic        busy,
  output logic        run_done,
  output logic [15:0] frames_done,
  output logic        err_in_len,
  output logic        err_out_len,
  output logic        stall_timeout,
  output logic [1:0]  stall_src,
  output logic [1:0]  state_dbg
);

  // Stream taps are passive monitors: a beat is counted only on TVALID & TREADY.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]  FLEN      = CNT_W'(FRAME_LEN);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_LIMIT - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   in_cnt, out_cnt;
  logic [CNT_W-1:0]   in_cnt_p1, out_cnt_p1;
  logic [CNT_W-1:0]   in_cnt_nxt, out_cnt_nxt;
  logic [WDOG_W-1:0]  wdog_cnt;
  logic [15:0]        num_frames;
  logic [15:0]        frames_inc;
  logic               abort_pending;
  logic               active, in_beat, out_beat, progress;
  logic               start_ok, wdog_hit, frame_end, run_end;
  logic               in_err, out_err;

  always_comb begin
    active     = (state == S_LOAD) || (state == S_DRAIN);
    in_beat    = in_tvalid & in_tready;
    out_beat   = out_tvalid & out_tready;
    progress   = in_beat | out_beat | kernel_ap_ready | kernel_ap_done;
    start_ok   = (state == S_IDLE) && cmd_start && cfg_enable;
    wdog_hit   = active && !progress && (wdog_cnt == WDOG_LAST);
    frame_end  = ((state == S_LOAD) && kernel_ap_ready && kernel_ap_done) ||
                 ((state == S_DRAIN) && kernel_ap_done);
    frames_inc = (frames_done == 16'hFFFF) ? frames_done : frames_done + 16'd1;
    run_end    = frame_end && (abort_pending ||
                 ((num_frames != 16'd0) && (frames_inc >= num_frames)));

    in_cnt_p1   = in_cnt + 1'b1;
    out_cnt_p1  = out_cnt + 1'b1;
    in_cnt_nxt  = (in_beat && in_cnt != FLEN) ? in_cnt_p1 : in_cnt;
    out_cnt_nxt = (out_beat && out_cnt != FLEN) ? out_cnt_p1 : out_cnt;
    // TLAST must coincide exactly with beat FRAME_LEN; any beat past it is an overrun.
    in_err  = in_beat && ((in_cnt == FLEN) || (in_tlast != (in_cnt_p1 == FLEN)));
    out_err = out_beat && ((out_cnt == FLEN) || (out_tlast != (out_cnt_p1 == FLEN)));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok) state_nxt = S_LOAD;
      S_LOAD: begin
        if (wdog_hit)             state_nxt = S_FAULT;
        else if (frame_end)       state_nxt = run_end ? S_IDLE : S_LOAD;
        else if (kernel_ap_ready) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (wdog_hit)       state_nxt = S_FAULT;
        else if (frame_end) state_nxt = run_end ? S_IDLE : S_LOAD;
      end
      S_FAULT: if (cmd_abort) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state         <= S_IDLE;
      run_done      <= 1'b0;
      frames_done   <= '0;
      num_frames    <= '0;
      in_cnt        <= '0;
      out_cnt       <= '0;
      wdog_cnt      <= '0;
      err_in_len    <= 1'b0;
      err_out_len   <= 1'b0;
      stall_timeout <= 1'b0;
      stall_src     <= '0;
      abort_pending <= 1'b0;
    end else begin
      state    <= state_nxt;
      run_done <= run_end;

      // Any state change (including LOAD->DRAIN) restarts the no-progress count.
      if (!active || progress || (state_nxt != state)) wdog_cnt <= '0;
      else                                             wdog_cnt <= wdog_cnt + 1'b1;

      if (start_ok || frame_end) begin
        in_cnt  <= '0;
        out_cnt <= '0;
      end else if (active) begin
        in_cnt  <= in_cnt_nxt;
        out_cnt <= out_cnt_nxt;
      end

      if (start_ok) begin
        num_frames    <= cfg_num_frames;
        frames_done   <= '0;
        err_in_len    <= 1'b0;
        err_out_len   <= 1'b0;
        stall_timeout <= 1'b0;
        stall_src     <= '0;
        abort_pending <= 1'b0;
      end else begin
        if (frame_end) frames_done <= frames_inc;
        if (active && in_err) err_in_len <= 1'b1;
        if (active && (out_err || (frame_end && out_cnt_nxt != FLEN))) err_out_len <= 1'b1;
        if (wdog_hit) begin
          stall_timeout <= 1'b1;
          stall_src     <= {out_tvalid & ~out_tready, in_tready & ~in_tvalid};
        end
        if (run_end || ((state == S_FAULT) && cmd_abort)) abort_pending <= 1'b0;
        else if (active && cmd_abort)                     abort_pending <= 1'b1;
      end
    end
  end

  assign busy            = (state != S_IDLE);
  assign kernel_ap_start = (state == S_LOAD);
  assign state_dbg       = state;

endmodule

// File: tb/tb_fft32_frame_sequencer.sv
// Directed bench for fft32_frame_sequencer: multi-frame runs, TLAST errors, abort,
// watchdog fault and restart, and asynchronous reset mid-run.
module tb_fft32_frame_sequencer;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        cfg_enable = 1'b0;
  logic [15:0] cfg_num_frames = '0;
  logic        cmd_start = 1'b0;
  logic        cmd_abort = 1'b0;
  logic        kernel_ap_start;
  logic        kernel_ap_ready = 1'b0;
  logic        kernel_ap_done = 1'b0;
  logic        in_tvalid = 1'b0, in_tready = 1'b0, in_tlast = 1'b0;
  logic        out_tvalid = 1'b0, out_tready = 1'b0, out_tlast = 1'b0;
  logic        busy, run_done, err_in_len, err_out_len, stall_timeout;
  logic [15:0] frames_done;
  logic [1:0]  stall_src, state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  int start_rises = 0;
  int rise_base;
  logic prev_start = 1'b0;

  fft32_frame_sequencer #(
    .FRAME_LEN(32), .CNT_W(6), .WDOG_W(16), .WDOG_LIMIT(8)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .cfg_enable(cfg_enable), .cfg_num_frames(cfg_num_frames),
    .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .kernel_ap_start(kernel_ap_start), .kernel_ap_ready(kernel_ap_ready),
    .kernel_ap_done(kernel_ap_done),
    .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tlast(in_tlast),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast),
    .busy(busy), .run_done(run_done), .frames_done(frames_done),
    .err_in_len(err_in_len), .err_out_len(err_out_len),
    .stall_timeout(stall_timeout), .stall_src(stall_src), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 ap_clk = ~ap_clk;

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit exceeded");
  end

  always @(negedge ap_clk) begin
    if (kernel_ap_start && !prev_start) start_rises = start_rises + 1;
    prev_start = kernel_ap_start;
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic pulse_start(input logic [15:0] num, input logic en, input logic abt);
    cfg_num_frames = num;
    cfg_enable     = en;
    cmd_start      = 1'b1;
    cmd_abort      = abt;
    tick();
    cmd_start = 1'b0;
    cmd_abort = 1'b0;
  endtask

  task automatic pulse_abort();
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
  endtask

  task automatic send_in(input int n, input int last_pos);
    for (int i = 0; i < n; i++) begin
      in_tvalid = 1'b1; in_tready = 1'b1; in_tlast = (i == last_pos);
      tick();
    end
    in_tvalid = 1'b0; in_tready = 1'b0; in_tlast = 1'b0;
  endtask

  task automatic send_out(input int n, input int last_pos);
    for (int i = 0; i < n; i++) begin
      out_tvalid = 1'b1; out_tready = 1'b1; out_tlast = (i == last_pos);
      tick();
    end
    out_tvalid = 1'b0; out_tready = 1'b0; out_tlast = 1'b0;
  endtask

  task automatic out_stall(input int n);
    out_tvalid = 1'b1; out_tready = 1'b0;
    for (int i = 0; i < n; i++) tick();
    out_tvalid = 1'b0;
  endtask

  task automatic pulse_ready();
    kernel_ap_ready = 1'b1;
    tick();
    kernel_ap_ready = 1'b0;
  endtask

  task automatic pulse_done();
    kernel_ap_done = 1'b1;
    tick();
    kernel_ap_done = 1'b0;
  endtask

  task automatic good_frame();
    send_in(32, 31);
    pulse_ready();
    send_out(32, 31);
    pulse_done();
  endtask

  initial begin
    repeat (3) tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ap_start", kernel_ap_start, 0);
    check_eq("rst_frames", frames_done, 0);
    check_eq("rst_flags", {run_done, err_in_len, err_out_len, stall_timeout, stall_src}, 0);
    ap_rst_n = 1'b1;
    tick();

    // start with enable low is ignored
    pulse_start(16'd3, 1'b0, 1'b0);
    check_eq("dis_start_busy", busy, 0);

    // three well-formed frames
    rise_base = start_rises;
    pulse_start(16'd3, 1'b1, 1'b0);
    check_eq("t1_ap_start", kernel_ap_start, 1);
    for (int f = 0; f < 3; f++) begin
      send_in(32, 31);
      pulse_ready();
      check_eq("t1_start_drop", kernel_ap_start, 0);
      send_out(32, 31);
      pulse_done();
      check_eq("t1_frames", frames_done, 16'(f + 1));
      check_eq("t1_run_done", run_done, (f == 2) ? 16'd1 : 16'd0);
    end
    check_eq("t1_busy_end", busy, 0);
    tick();
    check_eq("t1_run_done_pulse", run_done, 0);
    check_eq("t1_errs", {err_in_len, err_out_len}, 0);
    check_eq("t1_start_windows", 16'(start_rises - rise_base), 3);

    // input TLAST one beat early
    pulse_start(16'd1, 1'b1, 1'b0);
    send_in(32, 30);
    pulse_ready();
    send_out(32, 31);
    pulse_done();
    check_eq("t2_err_in", err_in_len, 1);
    check_eq("t2_err_out", err_out_len, 0);
    check_eq("t2_frames", frames_done, 1);
    check_eq("t2_run_done", run_done, 1);

    // continuous run aborted mid-DRAIN of frame 5
    rise_base = start_rises;
    pulse_start(16'd0, 1'b1, 1'b0);
    check_eq("t3_errs_cleared", {err_in_len, err_out_len}, 0);
    for (int f = 0; f < 4; f++) good_frame();
    check_eq("t3_frames4", frames_done, 4);
    send_in(32, 31);
    pulse_ready();
    send_out(10, -1);
    pulse_abort();
    check_eq("t3_still_busy", busy, 1);
    send_out(22, 21);
    pulse_done();
    check_eq("t3_frames", frames_done, 5);
    check_eq("t3_run_done", run_done, 1);
    check_eq("t3_idle", busy, 0);
    repeat (4) tick();
    check_eq("t3_start_windows", 16'(start_rises - rise_base), 5);
    check_eq("t3_err_out", err_out_len, 0);

    // starved input in LOAD trips the watchdog on the 8th idle cycle
    pulse_start(16'd1, 1'b1, 1'b0);
    in_tready = 1'b1;
    repeat (7) tick();
    check_eq("t4_no_fault_7", stall_timeout, 0);
    tick();
    in_tready = 1'b0;
    check_eq("t4_fault", stall_timeout, 1);
    check_eq("t4_src", stall_src, 2'b01);
    check_eq("t4_ap_start", kernel_ap_start, 0);
    repeat (5) tick();
    check_eq("t4_busy_hold", busy, 1);
    pulse_abort();
    check_eq("t4_abort_idle", busy, 0);
    check_eq("t4_no_run_done", run_done, 0);
    check_eq("t4_status_held", {stall_timeout, stall_src}, 3'b101);

    // backpressure of 7 cycles between beats never faults
    pulse_start(16'd1, 1'b1, 1'b0);
    check_eq("t5_stall_cleared", {stall_timeout, stall_src}, 0);
    send_in(32, 31);
    pulse_ready();
    send_out(1, -1);
    out_stall(7);
    send_out(1, -1);
    out_stall(7);
    check_eq("t5_no_fault", stall_timeout, 0);
    send_out(30, 29);
    pulse_done();
    check_eq("t5_frames", frames_done, 1);
    check_eq("t5_flags", {stall_timeout, err_out_len, err_in_len}, 0);

    // start+abort together in IDLE: start wins; then reset mid-DRAIN
    pulse_start(16'd2, 1'b1, 1'b1);
    good_frame();
    check_eq("t6_abort_ignored", busy, 1);
    check_eq("t6_frames1", frames_done, 1);
    send_in(32, -1);
    pulse_ready();
    send_out(5, -1);
    check_eq("t6_err_in_pre", err_in_len, 1);
    #2 ap_rst_n = 1'b0;
    #1;
    check_eq("t6_rst_busy", busy, 0);
    check_eq("t6_rst_frames", frames_done, 0);
    check_eq("t6_rst_flags", {kernel_ap_start, run_done, err_in_len, err_out_len, stall_timeout}, 0);
    tick();
    ap_rst_n = 1'b1;
    tick();
    pulse_start(16'd1, 1'b1, 1'b0);
    check_eq("t6_fresh_frames", frames_done, 0);
    check_eq("t6_fresh_ap_start", kernel_ap_start, 1);
    good_frame();
    check_eq("t6_fresh_done", {run_done, frames_done}, {1'b1, 16'd1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
